// File: rtl/llc_set_reader.sv
// LLC set reader: reads tag/state/evict RAMs for a requested set and pushes a lookup packet.
// Optional macro LLC_READ_BYPASS_EN forwards same-set RAM writes into the outgoing/held packet.
`ifndef LLC_WAYS
`define LLC_WAYS 4
`endif
`ifndef LLC_SET_BITS
`define LLC_SET_BITS 8
`endif
`ifndef LLC_TAG_BITS
`define LLC_TAG_BITS 8
`endif

package llc_set_reader_pkg;
    localparam int LLC_WAYS     = `LLC_WAYS;
    localparam int LLC_SET_BITS = `LLC_SET_BITS;
    localparam int LLC_TAG_BITS = `LLC_TAG_BITS;

    typedef logic [LLC_TAG_BITS-1:0]      llc_tag_t;
    typedef logic [$clog2(LLC_WAYS)-1:0]  llc_way_t;
    typedef enum logic [1:0] {INVALID = 2'd0, VALID = 2'd1, SHARED = 2'd2, MODIFIED = 2'd3} llc_state_t;

    typedef struct packed {
        llc_tag_t                          tag;
        logic [LLC_SET_BITS-1:0]           set;
        llc_tag_t   [LLC_WAYS-1:0]         tags_buf;
        llc_state_t [LLC_WAYS-1:0]         states_buf;
        llc_way_t                          evict_way_buf;
    } fifo_mem_lookup_packet;
endpackage

module llc_set_reader
    import llc_set_reader_pkg::*;
#(
    parameter int WAYS     = `LLC_WAYS,
    parameter int SET_BITS = `LLC_SET_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [SET_BITS-1:0]   req_set,
    input  llc_tag_t              req_tag,
    output logic                  rd_en,
    output logic [SET_BITS-1:0]   rd_set,
    input  llc_tag_t              tags_rd [WAYS],
    input  llc_state_t            states_rd [WAYS],
    input  llc_way_t              evict_way_rd,
    input  logic                  wr_en,
    input  logic [SET_BITS-1:0]   wr_set,
    input  llc_way_t              wr_way,
    input  llc_tag_t              wr_tag,
    input  llc_state_t            wr_state,
    input  logic                  fifo_full_lookup,
    output logic                  fifo_push_lookup,
    output fifo_mem_lookup_packet fifo_lookup_in
);
    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_HOLD} state_t;

    state_t               state_q, state_d;
    llc_tag_t             tag_q, tag_d;
    logic [SET_BITS-1:0]  set_q, set_d;
    llc_tag_t             hold_tags_q [WAYS];
    llc_tag_t             hold_tags_d [WAYS];
    llc_state_t           hold_states_q [WAYS];
    llc_state_t           hold_states_d [WAYS];
    llc_way_t             hold_evict_q, hold_evict_d;

    // RAM outputs as seen by this stage, possibly patched by a forwarded write
    llc_tag_t             ram_tags [WAYS];
    llc_state_t           ram_states [WAYS];

`ifdef LLC_READ_BYPASS_EN
    logic                 byp_vld_q, byp_vld_d;
    llc_way_t             byp_way_q;
    llc_tag_t             byp_tag_q;
    llc_state_t           byp_state_q;

    assign byp_vld_d = rd_en && wr_en && (wr_set == req_set);

    always_ff @(posedge clk) begin
        if (!rst) begin
            byp_vld_q   <= 1'b0;
            byp_way_q   <= '0;
            byp_tag_q   <= '0;
            byp_state_q <= INVALID;
        end else begin
            byp_vld_q <= byp_vld_d;
            if (byp_vld_d) begin
                byp_way_q   <= wr_way;
                byp_tag_q   <= wr_tag;
                byp_state_q <= wr_state;
            end
        end
    end
`else
    logic unused_wr;
    assign unused_wr = ^{wr_en, wr_set, wr_way, wr_tag, wr_state};
`endif

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            ram_tags[w]   = tags_rd[w];
            ram_states[w] = states_rd[w];
        end
`ifdef LLC_READ_BYPASS_EN
        if (byp_vld_q) begin
            ram_tags[byp_way_q]   = byp_tag_q;
            ram_states[byp_way_q] = byp_state_q;
        end
`endif
    end

    always_comb begin
        state_d          = state_q;
        tag_d            = tag_q;
        set_d            = set_q;
        hold_tags_d      = hold_tags_q;
        hold_states_d    = hold_states_q;
        hold_evict_d     = hold_evict_q;
        req_ready        = 1'b0;
        fifo_push_lookup = 1'b0;
        fifo_lookup_in   = '0;

        unique case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = ST_READ;
            end
            ST_READ: begin
                if (!fifo_full_lookup) begin
                    fifo_push_lookup             = 1'b1;
                    fifo_lookup_in.tag           = tag_q;
                    fifo_lookup_in.set           = set_q;
                    fifo_lookup_in.evict_way_buf = evict_way_rd;
                    for (int w = 0; w < WAYS; w++) begin
                        fifo_lookup_in.tags_buf[w]   = ram_tags[w];
                        fifo_lookup_in.states_buf[w] = ram_states[w];
                    end
                    req_ready = 1'b1;
                    state_d   = req_valid ? ST_READ : ST_IDLE;
                end else begin
                    hold_tags_d   = ram_tags;
                    hold_states_d = ram_states;
                    hold_evict_d  = evict_way_rd;
                    state_d       = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!fifo_full_lookup) begin
                    fifo_push_lookup             = 1'b1;
                    fifo_lookup_in.tag           = tag_q;
                    fifo_lookup_in.set           = set_q;
                    fifo_lookup_in.evict_way_buf = hold_evict_q;
                    for (int w = 0; w < WAYS; w++) begin
                        fifo_lookup_in.tags_buf[w]   = hold_tags_q[w];
                        fifo_lookup_in.states_buf[w] = hold_states_q[w];
                    end
                    state_d = ST_IDLE;
                end
`ifdef LLC_READ_BYPASS_EN
                if (wr_en && (wr_set == set_q)) begin
                    hold_tags_d[wr_way]   = wr_tag;
                    hold_states_d[wr_way] = wr_state;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        // Nothing leaves this block while reset is held
        if (!rst) begin
            req_ready        = 1'b0;
            fifo_push_lookup = 1'b0;
            fifo_lookup_in   = '0;
        end

        rd_en  = req_valid && req_ready;
        rd_set = req_set;
        if (rd_en) begin
            tag_d = req_tag;
            set_d = req_set;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            tag_q        <= '0;
            set_q        <= '0;
            hold_evict_q <= '0;
            for (int w = 0; w < WAYS; w++) begin
                hold_tags_q[w]   <= '0;
                hold_states_q[w] <= INVALID;
            end
        end else begin
            state_q       <= state_d;
            tag_q         <= tag_d;
            set_q         <= set_d;
            hold_tags_q   <= hold_tags_d;
            hold_states_q <= hold_states_d;
            hold_evict_q  <= hold_evict_d;
        end
    end
endmodule

// File: tb/tb_llc_set_reader.sv
// Directed bench for llc_set_reader: reset, single/back-to-back reads, FIFO-full hold,
// same-cycle write forwarding (both builds) and reset while holding.
module tb_llc_set_reader;
    import llc_set_reader_pkg::*;
    localparam int W  = LLC_WAYS;
    localparam int SB = LLC_SET_BITS;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  req_valid;
    logic                  req_ready;
    logic [SB-1:0]         req_set;
    llc_tag_t              req_tag;
    logic                  rd_en;
    logic [SB-1:0]         rd_set;
    llc_tag_t              tags_rd [W];
    llc_state_t            states_rd [W];
    llc_way_t              evict_way_rd;
    logic                  wr_en;
    logic [SB-1:0]         wr_set;
    llc_way_t              wr_way;
    llc_tag_t              wr_tag;
    llc_state_t            wr_state;
    logic                  fifo_full_lookup;
    logic                  fifo_push_lookup;
    fifo_mem_lookup_packet fifo_lookup_in;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    llc_set_reader dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_set(req_set), .req_tag(req_tag),
        .rd_en(rd_en), .rd_set(rd_set),
        .tags_rd(tags_rd), .states_rd(states_rd), .evict_way_rd(evict_way_rd),
        .wr_en(wr_en), .wr_set(wr_set), .wr_way(wr_way), .wr_tag(wr_tag), .wr_state(wr_state),
        .fifo_full_lookup(fifo_full_lookup), .fifo_push_lookup(fifo_push_lookup),
        .fifo_lookup_in(fifo_lookup_in)
    );

    // Fixed RAM contents: tag = {set[3:0], way}, state = (set+way)%4, evict = set%4;
    // set 5 way 2 holds tag 0x3A, VALID.
    function automatic llc_tag_t ram_tag(input logic [SB-1:0] s, input int w);
        if (s == 5 && w == 2) return 8'h3A;
        return {s[3:0], 4'(w)};
    endfunction
    function automatic llc_state_t ram_state(input logic [SB-1:0] s, input int w);
        if (s == 5 && w == 2) return VALID;
        return llc_state_t'(2'(int'(s) + w));
    endfunction

    // Read-first RAM with a single write overlay entry
    logic          ov_vld = 1'b0;
    logic [SB-1:0] ov_set;
    llc_way_t      ov_way;
    llc_tag_t      ov_tag;
    llc_state_t    ov_state;
    always @(posedge clk) begin
        if (rd_en) begin
            for (int w = 0; w < W; w++) begin
                if (ov_vld && ov_set == rd_set && int'(ov_way) == w) begin
                    tags_rd[w]   <= ov_tag;
                    states_rd[w] <= ov_state;
                end else begin
                    tags_rd[w]   <= ram_tag(rd_set, w);
                    states_rd[w] <= ram_state(rd_set, w);
                end
            end
            evict_way_rd <= llc_way_t'(rd_set);
        end
        if (wr_en) begin
            ov_vld   <= 1'b1;
            ov_set   <= wr_set;
            ov_way   <= wr_way;
            ov_tag   <= wr_tag;
            ov_state <= wr_state;
        end
    end

    function automatic fifo_mem_lookup_packet exp_pkt(input llc_tag_t t, input logic [SB-1:0] s);
        fifo_mem_lookup_packet p;
        p     = '0;
        p.tag = t;
        p.set = s;
        for (int w = 0; w < W; w++) begin
            p.tags_buf[w]   = ram_tag(s, w);
            p.states_buf[w] = ram_state(s, w);
        end
        p.evict_way_buf = llc_way_t'(s);
        return p;
    endfunction

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic v, input logic [SB-1:0] s, input llc_tag_t t);
        req_valid = v;
        req_set   = s;
        req_tag   = t;
    endtask

    fifo_mem_lookup_packet ep;
    fifo_mem_lookup_packet zero_pkt;

    initial begin
        zero_pkt = '0;
        rst = 1'b0; fifo_full_lookup = 1'b0;
        wr_en = 1'b0; wr_set = '0; wr_way = '0; wr_tag = '0; wr_state = INVALID;
        drive_req(1'b1, 8'd1, 8'h00);
        step(); step(); #1;
        check("rst_ready", req_ready, 1'b0);
        check("rst_rd_en", rd_en, 1'b0);
        check("rst_push", fifo_push_lookup, 1'b0);
        check("rst_pkt", fifo_lookup_in, zero_pkt);

        // Release reset, idle
        drive_req(1'b0, '0, '0);
        step(); rst = 1'b1; #1;
        check("idle_ready", req_ready, 1'b1);
        check("idle_rd_en", rd_en, 1'b0);

        // Single request, set 5 tag 0x3A
        step(); drive_req(1'b1, 8'd5, 8'h3A); #1;
        check("t1_rd_en", rd_en, 1'b1);
        check("t1_rd_set", rd_set, 8'd5);
        check("t1_nopush", fifo_push_lookup, 1'b0);
        step(); drive_req(1'b0, '0, '0); #1;
        check("t1_push", fifo_push_lookup, 1'b1);
        check("t1_pkt", fifo_lookup_in, exp_pkt(8'h3A, 8'd5));
        check("t1_way2", fifo_lookup_in.tags_buf[2], 8'h3A);
        step(); #1;
        check("t1_after_push", fifo_push_lookup, 1'b0);
        check("t1_after_pkt", fifo_lookup_in, zero_pkt);
        check("t1_after_ready", req_ready, 1'b1);

        // Back-to-back sets 1..4
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i <= 4) drive_req(1'b1, SB'(i), 8'hA0 + 8'(i));
            else        drive_req(1'b0, '0, '0);
            #1;
            check("b2b_ready", req_ready, 1'b1);
            check("b2b_rd_en", rd_en, (i <= 4) ? 1'b1 : 1'b0);
            check("b2b_push", fifo_push_lookup, (i > 1) ? 1'b1 : 1'b0);
            if (i > 1) check("b2b_pkt", fifo_lookup_in, exp_pkt(8'hA0 + 8'(i - 1), SB'(i - 1)));
        end
        step(); #1;
        check("b2b_idle_push", fifo_push_lookup, 1'b0);

        // FIFO full for 3 cycles after the read
        drive_req(1'b1, 8'd9, 8'h5C); #1;
        check("full_rd_en", rd_en, 1'b1);
        step(); drive_req(1'b0, '0, '0); fifo_full_lookup = 1'b1; #1;
        check("full_read_push", fifo_push_lookup, 1'b0);
        check("full_read_ready", req_ready, 1'b0);
        step(); drive_req(1'b1, 8'd6, 8'h66); #1;
        check("hold1_push", fifo_push_lookup, 1'b0);
        check("hold1_ready", req_ready, 1'b0);
        check("hold1_rd_en", rd_en, 1'b0);
        step(); drive_req(1'b0, '0, '0); #1;
        check("hold2_push", fifo_push_lookup, 1'b0);
        check("hold2_pkt", fifo_lookup_in, zero_pkt);
        step(); fifo_full_lookup = 1'b0; #1;
        check("hold_push", fifo_push_lookup, 1'b1);
        check("hold_pkt", fifo_lookup_in, exp_pkt(8'h5C, 8'd9));
        check("hold_push_ready", req_ready, 1'b0);
        step(); #1;
        check("hold_idle_ready", req_ready, 1'b1);
        check("hold_idle_push", fifo_push_lookup, 1'b0);

        // Same-cycle write to the set being read
        drive_req(1'b1, 8'd7, 8'h77);
        wr_en = 1'b1; wr_set = 8'd7; wr_way = 2'd1; wr_tag = 8'h11; wr_state = VALID; #1;
        check("byp_rd_en", rd_en, 1'b1);
        step(); drive_req(1'b0, '0, '0); wr_en = 1'b0; #1;
        ep = exp_pkt(8'h77, 8'd7);
`ifdef LLC_READ_BYPASS_EN
        ep.tags_buf[1]   = 8'h11;
        ep.states_buf[1] = VALID;
`else
        ep.tags_buf[1]   = 8'h71;
        ep.states_buf[1] = INVALID;
`endif
        check("byp_push", fifo_push_lookup, 1'b1);
        check("byp_pkt", fifo_lookup_in, ep);

        // Reset while in HOLD
        step(); drive_req(1'b1, 8'd12, 8'h4D); #1;
        step(); drive_req(1'b0, '0, '0); fifo_full_lookup = 1'b1; #1;
        check("rh_read_push", fifo_push_lookup, 1'b0);
        step(); rst = 1'b0; fifo_full_lookup = 1'b0; #1;
        check("rh_rst_ready", req_ready, 1'b0);
        check("rh_rst_push", fifo_push_lookup, 1'b0);
        step(); rst = 1'b1; #1;
        check("rh_after_push", fifo_push_lookup, 1'b0);
        check("rh_after_ready", req_ready, 1'b1);
        drive_req(1'b1, 8'd3, 8'h33); #1;
        check("rh_next_rd_en", rd_en, 1'b1);
        step(); drive_req(1'b0, '0, '0); #1;
        check("rh_next_push", fifo_push_lookup, 1'b1);
        check("rh_next_pkt", fifo_lookup_in, exp_pkt(8'h33, 8'd3));
        step(); #1;
        check("rh_next_idle", fifo_push_lookup, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
